// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: writable instruction memory with a registered fetch port.
//
// A fetch is accepted when fetch_req && fetch_ready. The word is read
// 1 + WAIT_CYCLES cycles later, and fetch_valid pulses for one cycle.
// fetch_data/fetch_fault hold their values until the next response.
// A load port writes one word per cycle, independent of the fetch FSM.
// flush drops the in-flight fetch.
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   fetch_req, fetch_addr    fetch request and byte address (latched on accept)
//   fetch_ready              a request can be accepted this cycle
//   fetch_valid              one-cycle response strobe
//   fetch_data, fetch_fault  response word and fault flag
//   flush                    abort the in-flight fetch (branch/jump redirect)
//   load_we, load_addr, load_data   single-word write port
//   load_par_flip            (INST_MEM_PARITY_EN only) store inverted parity
//
// Optional feature macro: INST_MEM_PARITY_EN adds one even-parity bit per word.
// It also adds the load_par_flip port, and a parity mismatch on read is
// reported as a fault.
module inst_mem_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] NOP_WORD    = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              flush,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
`ifdef INST_MEM_PARITY_EN
  input  logic              load_par_flip,
`endif
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_idx_q, addr_idx_d;
  logic             addr_bad_q, addr_bad_d;
  logic             resp_loaded_q, resp_loaded_d;  // a response word has been read since reset
  logic             resp_bad_q, resp_bad_d;        // that response had an address fault

  logic             accept;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             par_err;

  // Address decode. Any bit above the word index makes the address out of range.
  logic [IDX_W-1:0] fetch_idx, load_idx;
  logic             fetch_bad, load_bad;

  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign load_idx  = load_addr[IDX_W+1:2];
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDX_W + 2)) != '0);
  assign load_bad  = (load_addr[1:0] != 2'b00) || ((load_addr >> (IDX_W + 2)) != '0);

  // Storage holds data XOR NOP_WORD. Zero-initialised simulation storage
  // therefore reads back as NOP_WORD without an init loop.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word_q;
`ifdef INST_MEM_PARITY_EN
  logic              par_mem [DEPTH];
  logic              rd_par_q;
`endif

  // The write and the registered read sit in one block. A load to the word
  // being read on the same edge therefore returns the old contents.
  always_ff @(posedge clk) begin
    if (load_we && !load_bad) begin
      mem[load_idx] <= load_data ^ NOP_WORD;
`ifdef INST_MEM_PARITY_EN
      par_mem[load_idx] <= (^(load_data ^ NOP_WORD)) ^ load_par_flip;
`endif
    end
    if (rd_en) begin
      rd_word_q <= mem[rd_idx];
`ifdef INST_MEM_PARITY_EN
      rd_par_q  <= par_mem[rd_idx];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      addr_idx_q    <= '0;
      addr_bad_q    <= 1'b0;
      resp_loaded_q <= 1'b0;
      resp_bad_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_idx_q    <= addr_idx_d;
      addr_bad_q    <= addr_bad_d;
      resp_loaded_q <= resp_loaded_d;
      resp_bad_q    <= resp_bad_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_idx_d    = addr_idx_q;
    addr_bad_d    = addr_bad_q;
    resp_loaded_d = resp_loaded_q;
    resp_bad_d    = resp_bad_q;

    // flush re-opens the port while in WAIT, so that a redirect fetch can
    // replace the dropped one in the same cycle.
    fetch_ready = (state_q != WAIT) || flush;
    accept      = fetch_req && fetch_ready;

    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q <= 3'd1) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An accepted request overrides the per-state transition.
    if (accept) begin
      addr_idx_d = fetch_idx;
      addr_bad_d = fetch_bad;
      if (WAIT_CYCLES == 0) begin
        state_d = RESP;
        cnt_d   = 3'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = WAIT_INIT;
      end
    end

    // Every edge into RESP starts a new response. With zero wait states,
    // the address being accepted on that edge is the one to read.
    rd_en  = (state_d == RESP);
    rd_idx = accept ? fetch_idx : addr_idx_q;
    if (rd_en) begin
      resp_loaded_d = 1'b1;
      resp_bad_d    = accept ? fetch_bad : addr_bad_q;
    end
  end

`ifdef INST_MEM_PARITY_EN
  assign par_err = resp_loaded_q && ((^rd_word_q) != rd_par_q);
`else
  assign par_err = 1'b0;
`endif

  assign fetch_valid = (state_q == RESP) && !flush;
  assign fetch_fault = resp_loaded_q && (resp_bad_q || par_err);
  assign fetch_data  = (resp_loaded_q && !fetch_fault) ? (rd_word_q ^ NOP_WORD) : NOP_WORD;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Testbench for inst_mem_ctrl. Three instances share the load and flush
// inputs. Each instance has a different wait-state count (0, 1, 3) and its
// own fetch_req. The reference memory is a plain array updated with the
// load rules.
module tb_inst_mem_ctrl;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h00000000;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [2:0]    req;
  logic [AW-1:0] faddr;
  logic          flush;
  logic          load_we;
  logic [AW-1:0] laddr;
  logic [DW-1:0] ldata;
  logic          par_flip;
  logic [2:0]    ready, valid, fault;
  logic [DW-1:0] data [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_m     [256];
  logic        par_bad_m [256];

  inst_mem_ctrl #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .fetch_req(req[0]), .fetch_addr(faddr),
    .fetch_ready(ready[0]), .fetch_valid(valid[0]), .fetch_data(data[0]),
    .fetch_fault(fault[0]), .flush(flush), .load_we(load_we), .load_addr(laddr),
`ifdef INST_MEM_PARITY_EN
    .load_par_flip(par_flip),
`endif
    .load_data(ldata));

  inst_mem_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .fetch_req(req[1]), .fetch_addr(faddr),
    .fetch_ready(ready[1]), .fetch_valid(valid[1]), .fetch_data(data[1]),
    .fetch_fault(fault[1]), .flush(flush), .load_we(load_we), .load_addr(laddr),
`ifdef INST_MEM_PARITY_EN
    .load_par_flip(par_flip),
`endif
    .load_data(ldata));

  inst_mem_ctrl #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .fetch_req(req[2]), .fetch_addr(faddr),
    .fetch_ready(ready[2]), .fetch_valid(valid[2]), .fetch_data(data[2]),
    .fetch_fault(fault[2]), .flush(flush), .load_we(load_we), .load_addr(laddr),
`ifdef INST_MEM_PARITY_EN
    .load_par_flip(par_flip),
`endif
    .load_data(ldata));

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic logic exp_fault(input logic [31:0] a);
    if (!addr_ok(a)) return 1'b1;
    return par_bad_m[a / 4];
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    if (exp_fault(a)) return NOP;
    return mem_m[a / 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic void model_load(input logic [31:0] a, input logic [31:0] d, input logic flip);
    if (addr_ok(a)) begin
      mem_m[a / 4]     = d;
      par_bad_m[a / 4] = flip;
    end
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic flip);
    laddr    = a;
    ldata    = d;
    load_we  = 1'b1;
`ifdef INST_MEM_PARITY_EN
    par_flip = flip;
`endif
    tick();
    load_we  = 1'b0;
    par_flip = 1'b0;
    model_load(a, d, flip);
    $display("load  addr=%08h data=%08h flip=%0d", a, d, flip);
  endtask

  // One complete fetch on instance k: accept, then the latency and response
  // checks, then a check that the data holds after the pulse.
  task automatic fetch(input int k, input logic [31:0] a, input string tag);
    logic [31:0] ed;
    logic        ef;
    ed = exp_data(a);
    ef = exp_fault(a);
    req[k] = 1'b1;
    faddr  = a;
    #1;
    chk({tag, "/ready"}, 32'(ready[k]), 32'd1);
    tick();
    req[k] = 1'b0;
    faddr  = $urandom;
    for (int i = 0; i < wc(k); i++) begin
      chk({tag, "/early_valid"}, 32'(valid[k]), 32'd0);
      chk({tag, "/busy"}, 32'(ready[k]), 32'd0);
      tick();
    end
    chk({tag, "/valid"}, 32'(valid[k]), 32'd1);
    chk({tag, "/data"}, data[k], ed);
    chk({tag, "/fault"}, 32'(fault[k]), 32'(ef));
    $display("fetch w%0d addr=%08h data=%08h fault=%0d", wc(k), a, data[k], fault[k]);
    tick();
    chk({tag, "/pulse"}, 32'(valid[k]), 32'd0);
    chk({tag, "/hold"}, data[k], ed);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
    if (r == 1) return 32'h400 + $urandom_range(0, 1023) * 4;
    return $urandom_range(0, 255) * 4;
  endfunction

  initial begin
    logic [31:0] old_w;
    for (int i = 0; i < 256; i++) begin
      mem_m[i]     = NOP;
      par_bad_m[i] = 1'b0;
    end
    reset_n  = 1'b0;
    req      = 3'b000;
    faddr    = '0;
    flush    = 1'b0;
    load_we  = 1'b0;
    laddr    = '0;
    ldata    = '0;
    par_flip = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst/valid", 32'(valid[k]), 32'd0);
      chk("rst/data", data[k], NOP);
      chk("rst/fault", 32'(fault[k]), 32'd0);
      chk("rst/ready", 32'(ready[k]), 32'd1);
    end
    reset_n = 1'b1;
    tick();

    do_load(32'h0, 32'h20100000, 1'b0);
    do_load(32'h4, 32'h8e110000, 1'b0);
    do_load(32'h8, 32'hcafef00d, 1'b0);

    // Single fetch with one wait state.
    fetch(1, 32'h4, "w1_fetch4");

    // Back-to-back fetches with zero wait states: one pulse per cycle, in order.
    req[0] = 1'b1;
    faddr  = 32'h0;
    tick();
    chk("b2b/v0", 32'(valid[0]), 32'd1);
    chk("b2b/d0", data[0], mem_m[0]);
    faddr = 32'h4;
    #1;
    chk("b2b/ready", 32'(ready[0]), 32'd1);
    tick();
    chk("b2b/v1", 32'(valid[0]), 32'd1);
    chk("b2b/d1", data[0], mem_m[1]);
    faddr = 32'h8;
    tick();
    chk("b2b/v2", 32'(valid[0]), 32'd1);
    chk("b2b/d2", data[0], mem_m[2]);
    req[0] = 1'b0;
    tick();
    chk("b2b/end", 32'(valid[0]), 32'd0);

    // Address faults are still delivered with normal latency.
    fetch(1, 32'h6, "fault_misalign");
    fetch(1, 32'h400, "fault_range");
    fetch(0, 32'h80000000, "fault_msb");
    fetch(2, 32'h3fd, "fault_w3");

    // Flush in WAIT drops the fetch.
    req[2] = 1'b1;
    faddr  = 32'h0;
    tick();
    req[2] = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flush/v", 32'(valid[2]), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush/idle", 32'(ready[2]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("flush/novalid", 32'(valid[2]), 32'd0);
      tick();
    end

    // Flush together with a new request: only the new word comes back.
    req[2] = 1'b1;
    faddr  = 32'h0;
    tick();
    req[2] = 1'b0;
    tick();
    chk("redir/busy", 32'(ready[2]), 32'd0);
    flush  = 1'b1;
    req[2] = 1'b1;
    faddr  = 32'h4;
    #1;
    chk("redir/ready", 32'(ready[2]), 32'd1);
    tick();
    flush  = 1'b0;
    req[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("redir/early", 32'(valid[2]), 32'd0);
      tick();
    end
    chk("redir/v", 32'(valid[2]), 32'd1);
    chk("redir/d", data[2], mem_m[1]);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("redir/once", 32'(valid[2]), 32'd0);
      tick();
    end

    // A load on the edge that enters RESP is not seen; a re-fetch sees it.
    old_w  = mem_m[2];
    req[1] = 1'b1;
    faddr  = 32'h8;
    tick();
    req[1]  = 1'b0;
    laddr   = 32'h8;
    ldata   = 32'h1131000a;
    load_we = 1'b1;
    tick();
    load_we = 1'b0;
    model_load(32'h8, 32'h1131000a, 1'b0);
    chk("rbw/v", 32'(valid[1]), 32'd1);
    chk("rbw/old", data[1], old_w);
    $display("fetch w1 addr=00000008 data=%08h (same-edge load)", data[1]);
    tick();
    fetch(1, 32'h8, "rbw_refetch");

    // A load landing during WAIT is seen.
    req[2] = 1'b1;
    faddr  = 32'hc;
    tick();
    req[2]  = 1'b0;
    laddr   = 32'hc;
    ldata   = 32'h0badc0de;
    load_we = 1'b1;
    tick();
    load_we = 1'b0;
    model_load(32'hc, 32'h0badc0de, 1'b0);
    chk("wload/v0", 32'(valid[2]), 32'd0);
    tick();
    chk("wload/v1", 32'(valid[2]), 32'd0);
    tick();
    chk("wload/v", 32'(valid[2]), 32'd1);
    chk("wload/d", data[2], 32'h0badc0de);
    tick();

    // Flush in RESP masks the pulse.
    req[1] = 1'b1;
    faddr  = 32'h4;
    tick();
    req[1] = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flush_resp/v", 32'(valid[1]), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_resp/after", 32'(valid[1]), 32'd0);

    // Asynchronous reset in the middle of WAIT: outputs clear at once and
    // memory contents survive.
    req[2] = 1'b1;
    faddr  = 32'h0;
    tick();
    req[2] = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst/v", 32'(valid[2]), 32'd0);
    chk("arst/d", data[2], NOP);
    chk("arst/f", 32'(fault[2]), 32'd0);
    chk("arst/ready", 32'(ready[2]), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    fetch(2, 32'h0, "arst_refetch");

`ifdef INST_MEM_PARITY_EN
    do_load(32'h10, 32'h12345678, 1'b1);
    fetch(1, 32'h10, "par_bad");
    do_load(32'h10, 32'h12345678, 1'b0);
    fetch(1, 32'h10, "par_good");
`endif

    // Random loads and fetches against the array model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
`ifdef INST_MEM_PARITY_EN
        do_load(rand_addr(), $urandom, ($urandom_range(0, 7) == 0));
`else
        do_load(rand_addr(), $urandom, 1'b0);
`endif
      end
      fetch(int'($urandom_range(0, 2)), rand_addr(), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
